// File: rtl/ddfs_nco_if.sv
// Control/sample bundle between the function-generator sequencer and ddfs_nco.
// The amp input exists only when DDFS_AMP_EN is defined.
interface ddfs_nco_if #(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 12,
    parameter int AMP_W   = 8
);
    logic               tick;
    logic               sync;
    logic [1:0]         mode;
    logic [PHASE_W-1:0] fw;
    logic [PHASE_W-1:0] phase_off;
`ifdef DDFS_AMP_EN
    logic [AMP_W:0]     amp;
`endif
    logic [DATA_W-1:0]  q_out;
    logic               q_valid;
    logic               wrap;

`ifdef DDFS_AMP_EN
    modport master (output tick, sync, mode, fw, phase_off, amp,
                    input  q_out, q_valid, wrap);
    modport slave  (input  tick, sync, mode, fw, phase_off, amp,
                    output q_out, q_valid, wrap);
`else
    modport master (output tick, sync, mode, fw, phase_off,
                    input  q_out, q_valid, wrap);
    modport slave  (input  tick, sync, mode, fw, phase_off,
                    output q_out, q_valid, wrap);
`endif
endinterface

// File: rtl/ddfs_nco.sv
// Direct digital frequency synthesiser: phase accumulator, quarter-wave sine ROM, triangle/square/saw.
// Define DDFS_AMP_EN to add an amplitude-scaling stage (amp input, latency 3 -> 4).
module ddfs_nco #(
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 12,
    parameter int AMP_W   = 8
) (
    input logic       clk,
    input logic       rst,
    ddfs_nco_if.slave bus
);
    localparam int LUT_N = 2 ** ADDR_W;
    localparam int LUT_W = DATA_W - 1;
    localparam int TOP_W = DATA_W + 1;
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MID_M1 = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        WAVE_SINE = 2'b00,
        WAVE_TRI  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_SAW  = 2'b11
    } wave_e;

    // Integer Taylor series in Q30 so the ROM contents are fixed at elaboration without real math.
    function automatic logic [LUT_W-1:0] sin_word(input int unsigned i);
        longint theta, term, sum, res;
        theta = (64'sd1686629713 * longint'(i)) / longint'(LUT_N - 1);
        term  = theta;
        sum   = theta;
        for (int unsigned k = 1; k <= 7; k++) begin
            term = (term * theta) >>> 30;
            term = (term * theta) >>> 30;
            term = -term / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        res = (longint'(2 ** LUT_W - 1) * sum + (64'sd1 <<< 29)) >>> 30;
        if (res < 0) res = 0;
        if (res > longint'(2 ** LUT_W - 1)) res = longint'(2 ** LUT_W - 1);
        return LUT_W'(res);
    endfunction

    logic [LUT_W-1:0] sin_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        localparam logic [LUT_W-1:0] WORD = sin_word(g);
        assign sin_rom[g] = WORD;
    end

    // Phase accumulator
    logic [PHASE_W-1:0] acc, fw_act, inc;
    logic [PHASE_W:0]   acc_sum;
    logic               adv;
    logic               wrap_q;

    always_comb begin
        inc     = (fw_act == '0) ? bus.fw : fw_act;
        acc_sum = {1'b0, acc} + {1'b0, inc};
        adv     = bus.tick && !bus.sync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            fw_act <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= adv && acc_sum[PHASE_W];
            if (bus.sync) begin
                acc    <= '0;
                fw_act <= bus.fw;
            end else begin
                if (bus.tick) acc <= acc_sum[PHASE_W-1:0];
                if ((bus.tick && acc_sum[PHASE_W]) || fw_act == '0) fw_act <= bus.fw;
            end
        end
    end

    // Stage 1: offset phase and mode, both taken from the pre-increment accumulator cycle
    logic [PHASE_W-1:0] p1;
    wave_e              mode1;
    logic               v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1    <= '0;
            mode1 <= WAVE_SINE;
            v1    <= 1'b0;
        end else begin
            p1    <= acc + bus.phase_off;
            mode1 <= wave_e'(bus.mode);
            v1    <= adv;
        end
    end

    // Stage 2: quarter-wave ROM read with mirrored address in odd quadrants
    logic [1:0]        quad1;
    logic [ADDR_W-1:0] idx1, lut_addr;
    logic [LUT_W-1:0]  lut_q;
    logic [TOP_W-1:0]  top2;
    wave_e             mode2;
    logic              v2;

    always_comb begin
        quad1    = p1[PHASE_W-1 -: 2];
        idx1     = p1[PHASE_W-3 -: ADDR_W];
        lut_addr = quad1[0] ? ~idx1 : idx1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_q <= '0;
            top2  <= '0;
            mode2 <= WAVE_SINE;
            v2    <= 1'b0;
        end else begin
            lut_q <= sin_rom[lut_addr];
            top2  <= p1[PHASE_W-1 -: TOP_W];
            mode2 <= mode1;
            v2    <= v1;
        end
    end

    // Stage 3: waveform shaping
    logic [DATA_W-1:0] lut_ext, samp;
    logic [1:0]        quad2;

    always_comb begin
        lut_ext = {1'b0, lut_q};
        quad2   = top2[DATA_W -: 2];
        samp    = MID;
        unique case (mode2)
            WAVE_SINE: samp = quad2[1] ? (MID_M1 - lut_ext) : (MID + lut_ext);
            WAVE_TRI:  samp = top2[DATA_W] ? ~top2[DATA_W-1:0] : top2[DATA_W-1:0];
            WAVE_SQR:  samp = top2[DATA_W] ? '0 : '1;
            WAVE_SAW:  samp = top2[DATA_W:1];
        endcase
    end

    logic [DATA_W-1:0] q_out_q;
    logic              q_valid_q;

`ifdef DDFS_AMP_EN
    localparam int PW = DATA_W + AMP_W + 3;
    localparam logic [AMP_W:0] AMP_ONE = {1'b1, {AMP_W{1'b0}}};

    logic [DATA_W-1:0]    s3, amp_out;
    logic                 v3;
    logic [AMP_W:0]       amp_c;
    logic signed [PW-1:0] dev, gain, scaled;

    // Stage 4: scale the deviation from midscale; >>> on the signed product floors
    always_comb begin
        amp_c   = (bus.amp > AMP_ONE) ? AMP_ONE : bus.amp;
        dev     = $signed(PW'(s3)) - $signed(PW'(MID));
        gain    = $signed(PW'(amp_c));
        scaled  = (dev * gain) >>> AMP_W;
        amp_out = MID + scaled[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3        <= MID;
            v3        <= 1'b0;
            q_out_q   <= MID;
            q_valid_q <= 1'b0;
        end else begin
            v3        <= v2;
            q_valid_q <= v3;
            if (v2) s3 <= samp;
            if (v3) q_out_q <= amp_out;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_out_q   <= MID;
            q_valid_q <= 1'b0;
        end else begin
            q_valid_q <= v2;
            if (v2) q_out_q <= samp;
        end
    end
`endif

    assign bus.q_out   = q_out_q;
    assign bus.q_valid = q_valid_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: doc/ddfs_nco.md
Name: ddfs_nco

Overview:
- Parametrised direct digital frequency synthesiser (NCO) for the function generator datapath.
- Phase accumulator width, LUT depth and sample width are independent parameters.
- Waveforms: sine (quarter-wave ROM with full symmetry decode), triangle, square, sawtooth.
- Adds phase offset, glitch-free frequency update at cycle wrap, sync restart, and valid/wrap strobes; sits between freq_divider (tick source) and the VGA DAC output stage.

Parameters:
- PHASE_W, 24, accumulator width; legal only when PHASE_W >= ADDR_W+2 and PHASE_W >= DATA_W+1.
- ADDR_W, 10, quarter-wave sin_lut address width; sin_lut depth is 2**ADDR_W.
- DATA_W, 12, output sample width, unsigned offset-binary.
- AMP_W, 8, amplitude fraction bits; used only with DDFS_AMP_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  sample-rate enable; the accumulator advances only in cycles where tick=1.
- sync  in  1  phase restart.
- mode  in  2  waveform select: 00 sine, 01 triangle, 10 square, 11 sawtooth.
- fw  in  PHASE_W  frequency word (phase increment).
- phase_off  in  PHASE_W  phase offset.
- q_out  out  DATA_W  sample.
- q_valid  out  1  one-cycle pulse when q_out holds a new sample.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

Behaviour:
- Reset:
  - Clears acc, fw_act, all pipeline registers and strobes.
  - q_out = 2**(DATA_W-1) (midscale); q_valid=0; wrap=0.
  - Reset asserted mid-operation discards in-flight samples with no partial output.
- Accumulator, priority sync > tick:
  - sync=1: acc<=0 and fw_act<=fw; no sample is issued; pipeline is not flushed.
  - else tick=1: acc<=acc+fw_act modulo 2**PHASE_W.
  - fw_act<=fw when the addition carries out, or when fw_act==0, so start-up does not stall.
  - Otherwise fw_act holds: a changed fw takes effect only at the next wrap, so there are no mid-period glitches.
- wrap: registered copy of the carry; high in cycle T+1 for a carry in tick cycle T.
- Pipeline, free-running on clk, valid token tracks tick (and is not generated by sync):
  - Stage 1 (edge ending T): p<=acc+phase_off, using the pre-increment acc; mode is registered alongside.
  - Stage 2 (edge ending T+1): sin_lut reads with 1-cycle registered latency. quad=p[PHASE_W-1:PHASE_W-2]; idx=next ADDR_W bits. LUT address = quad[0] ? ~idx : idx.
  - Stage 3 (edge ending T+2): q_out registered; q_valid=1 in cycle T+3. Latency is 3 cycles.
- Waveforms (M=2**(DATA_W-1); L = LUT word, range 0..M-1):
  - sine: M+L for quad 0,1; M-1-L for quad 2,3.
  - triangle: t = top DATA_W+1 bits of p; out = t[DATA_W]? ~t[DATA_W-1:0] : t[DATA_W-1:0].
  - square: p MSB=0 gives all ones; MSB=1 gives 0.
  - sawtooth: top DATA_W bits of p.
  - Other modes use the same stage-2/3 timing as sine, so latency is mode-independent.
- Mode change takes effect on the first sample whose stage-1 capture follows it; there is no mixed-mode sample.
- Back-to-back ticks give one sample per cycle. With tick=0, q_out holds and q_valid=0.

Optional Feature:
- DDFS_AMP_EN defined:
  - Adds input amp, width AMP_W+1; values above 2**AMP_W are clamped to 2**AMP_W.
  - Adds stage 4, so latency becomes 4: q_out = M + (((s-M)*amp) >>> AMP_W), using signed arithmetic with floor rounding.
  - amp=2**AMP_W reproduces s exactly.
- DDFS_AMP_EN undefined: no amp port; latency is 3.

Test Plan (PHASE_W=12, ADDR_W=8, DATA_W=10, LUT[0]=0, LUT[255]=511):
- rst=1 mid-stream -> q_out=512, q_valid=0, wrap=0 immediately; after release with tick=0, outputs hold indefinitely.
- mode=11, fw=4, tick every cycle from reset -> q_out=0,1,2,... starting 3 cycles after the first tick; q_valid high every cycle; wrap pulses every 1024 ticks.
- mode=00, fw=0x400, phase_off=0 -> q_out sequence 512,1023,511,0 repeating at 1 sample per tick; wrap after every 4th tick.
- fw changed 0x400->0x200 at tick 2 -> increments stay 0x400 until carry, then 0x200; no sample skipped.
- sync=1 with tick=1 in the same cycle -> acc=0, no q_valid 3 cycles later; next tick yields the phase-0 sample (512 for sine).
- DDFS_AMP_EN, mode=10, amp=0 -> q_out=512 constant; amp=256 -> q_out toggles 1023/0 with latency 4.
